// File: rtl/dds_multi_ctrl_if.sv
// dds_multi_ctrl_if: command handshake between the control FSM and the DDS controller
interface dds_multi_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int FREQ_W = 24
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [CW-1:0]     cmd_ch;
  logic [FREQ_W-1:0] cmd_freq;
  logic [11:0]       cmd_phase;
  logic [1:0]        cmd_wave;
  logic              cmd_done;
  logic              cmd_err;
  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_freq, cmd_phase, cmd_wave,
    input  cmd_ready, cmd_done, cmd_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_freq, cmd_phase, cmd_wave,
    output cmd_ready, cmd_done, cmd_err
  );
endinterface

// File: rtl/dds_multi_ctrl.sv
// dds_multi_ctrl: multi-channel AD9833-class DDS controller with built-in SPI word shifter
module dds_multi_ctrl #(
  parameter int NUM_CH    = 2,
  parameter int FREQ_W    = 24,
  parameter int FTW_MULT  = 703687,
  parameter int FTW_SHIFT = 16,
  parameter int SCLK_HALF = 2,
  parameter int FSYNC_GAP = 4
) (
  input  logic              clk,
  input  logic              rst_l,
  dds_multi_ctrl_if.slave   bus,
  output logic              sg_sclk,
  output logic              sg_sdata,
  output logic [NUM_CH-1:0] sg_fsync,
  output logic [2:0]        sg_state
);
  localparam int CW   = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int PW   = FREQ_W + 20;
  localparam int DMAX = SCLK_HALF > FSYNC_GAP ? SCLK_HALF : FSYNC_GAP;
  localparam int DW   = $clog2(DMAX + 1);
  localparam logic [1:0] OP_INIT = 2'd0, OP_SET = 2'd1, OP_EN = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic [CW-1:0]     r_ch;
  logic [FREQ_W-1:0] r_freq;
  logic [11:0]       r_phase;
  logic [1:0]        r_idx;
  logic [27:0]       r_ftw;
  logic [15:0]       r_sh;
  logic [DW-1:0]     r_div;
  logic [4:0]        r_half;
  logic [1:0]        r_wave [NUM_CH];
  logic              r_ready, r_done, r_err, r_sclk, r_sdata;
  logic [NUM_CH-1:0] r_fsync;

  logic [PW-1:0] w_prod, w_sh;
  logic [27:0]   w_ftw;
  logic [15:0]   w_m, w_word;
  logic          w_acc, w_bad, w_last;

  function automatic logic [15:0] f_mode(input logic [1:0] w);
    return w == 2'd1 ? 16'h0002 : w == 2'd2 ? 16'h0028 : w == 2'd3 ? 16'h0020 : 16'h0000;
  endfunction

  // tuning word from the latched frequency, saturated to 28 bits
  always_comb begin
    w_prod = PW'(r_freq) * PW'(FTW_MULT);
    w_sh   = w_prod >> FTW_SHIFT;
    w_ftw  = w_sh > PW'(28'hFFFFFFF) ? 28'hFFFFFFF : w_sh[27:0];
  end

  // next 16-bit word for the current opcode and word index
  always_comb begin
    w_m    = f_mode(r_wave[r_ch]);
    w_word = r_op == OP_INIT ? 16'h2100 :
             r_op == OP_EN   ? 16'h2000 | w_m :
             r_op != OP_SET  ? 16'h2100 | w_m :
             r_idx == 2'd0   ? 16'h2100 | w_m :
             r_idx == 2'd1   ? {2'b01, r_ftw[13:0]} :
             r_idx == 2'd2   ? {2'b01, r_ftw[27:14]} : {4'hC, r_phase};
    w_last = r_op != OP_SET || r_idx == 2'd3;
    w_acc  = bus.cmd_valid && r_ready;
    w_bad  = 32'(bus.cmd_ch) >= NUM_CH;
  end

  // sequencing FSM; all pin and handshake outputs are registered here
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_ch    <= '0;
      r_freq  <= '0;
      r_phase <= '0;
      r_idx   <= 2'd0;
      r_ftw   <= '0;
      r_sh    <= '0;
      r_div   <= '0;
      r_half  <= '0;
      r_wave  <= '{default: 2'd0};
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_sclk  <= 1'b1;
      r_sdata <= 1'b0;
      r_fsync <= '1;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
          if (w_acc && w_bad) r_err <= 1'b1;
          else if (w_acc) begin
            r_ready <= 1'b0;
            r_state <= S_LOAD;
            r_op    <= bus.cmd_op;
            r_ch    <= bus.cmd_ch;
            r_freq  <= bus.cmd_freq;
            r_phase <= bus.cmd_phase;
            r_idx   <= 2'd0;
            if (bus.cmd_op == OP_INIT) r_wave[bus.cmd_ch] <= 2'd0;
            else if (bus.cmd_op == OP_SET) r_wave[bus.cmd_ch] <= bus.cmd_wave;
          end
        end
        S_LOAD: begin
          if (r_idx == 2'd0) r_ftw <= w_ftw;
          r_sh    <= {w_word[14:0], 1'b0};
          r_sdata <= w_word[15];
          r_sclk  <= 1'b1;
          r_fsync <= ~(NUM_CH'(1) << r_ch);
          r_div   <= '0;
          r_half  <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT:
          if (r_div == DW'(SCLK_HALF - 1)) begin
            r_div  <= '0;
            r_half <= r_half + 5'd1;
            if (!r_half[0]) r_sclk <= 1'b0;
            else begin
              r_sclk <= 1'b1;
              if (r_half == 5'd31) begin
                r_fsync <= '1;
                r_sdata <= 1'b0;
                r_state <= S_GAP;
              end else begin
                r_sdata <= r_sh[15];
                r_sh    <= {r_sh[14:0], 1'b0};
              end
            end
          end else r_div <= r_div + DW'(1);
        S_GAP:
          if (r_div == DW'(FSYNC_GAP - 1)) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
            end else r_state <= S_LOAD;
          end else r_div <= r_div + DW'(1);
        default: r_state <= S_IDLE;
      endcase
    end

  assign bus.cmd_ready = r_ready;
  assign bus.cmd_done  = r_done;
  assign bus.cmd_err   = r_err;
  assign sg_sclk       = r_sclk;
  assign sg_sdata      = r_sdata;
  assign sg_fsync      = r_fsync;
  assign sg_state      = r_state;
endmodule

// File: tb/tb_dds_multi_ctrl.sv
// tb_dds_multi_ctrl: directed checks of the DDS controller (default instance A, fast 3-channel instance B)
module tb_dds_multi_ctrl;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  dds_multi_ctrl_if #(.NUM_CH(2), .FREQ_W(24)) ba ();
  dds_multi_ctrl_if #(.NUM_CH(3), .FREQ_W(24)) bb ();

  logic       sclk_a, sdata_a, sclk_b, sdata_b;
  logic [1:0] fs_a;
  logic [2:0] fs_b, st_a, st_b;

  dds_multi_ctrl u_a (
    .clk(clk), .rst_l(rst_a), .bus(ba),
    .sg_sclk(sclk_a), .sg_sdata(sdata_a), .sg_fsync(fs_a), .sg_state(st_a)
  );
  dds_multi_ctrl #(.NUM_CH(3), .SCLK_HALF(1), .FSYNC_GAP(1)) u_b (
    .clk(clk), .rst_l(rst_b), .bus(bb),
    .sg_sclk(sclk_b), .sg_sdata(sdata_b), .sg_fsync(fs_b), .sg_state(st_b)
  );

  int vecs = 0;
  int errs = 0;

  logic [2:0]  fs [2];
  logic        sc [2];
  logic        sd [2];
  logic [2:0]  p_fs [2] = '{3'b111, 3'b111};
  logic        p_sc [2] = '{1'b1, 1'b1};
  logic [15:0] cur_sh [2];
  int          cur_bits [2] = '{0, 0};
  int          cur_low [2] = '{0, 0};
  int          cur_ch [2] = '{0, 0};
  logic [15:0] m_word [2][64];
  int          m_ch [2][64];
  int          m_low [2][64];
  int          m_bits [2][64];
  int          m_n [2] = '{0, 0};
  int          n_multi = 0;

  assign fs[0] = {1'b1, fs_a};
  assign fs[1] = fs_b;
  assign sc[0] = sclk_a;
  assign sc[1] = sclk_b;
  assign sd[0] = sdata_a;
  assign sd[1] = sdata_b;

  // device model: sample sdata on falling sclk while a frame sync is low, log each frame
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (fs[i] != 3'b111) begin
        cur_low[i] <= cur_low[i] + 1;
        for (int k = 0; k < 3; k++) if (!fs[i][k]) cur_ch[i] <= k;
        if ($countones(~fs[i]) > 1) n_multi <= n_multi + 1;
        if (p_sc[i] && !sc[i]) begin
          cur_sh[i]   <= {cur_sh[i][14:0], sd[i]};
          cur_bits[i] <= cur_bits[i] + 1;
        end
      end else if (p_fs[i] != 3'b111) begin
        if (m_n[i] < 64) begin
          m_word[i][m_n[i]] <= cur_sh[i];
          m_ch[i][m_n[i]]   <= cur_ch[i];
          m_low[i][m_n[i]]  <= cur_low[i];
          m_bits[i][m_n[i]] <= cur_bits[i];
        end
        m_n[i]      <= m_n[i] + 1;
        cur_low[i]  <= 0;
        cur_bits[i] <= 0;
        cur_sh[i]   <= 16'h0;
      end
      p_sc[i] <= sc[i];
      p_fs[i] <= fs[i];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int s);
    return s != 0 ? bb.cmd_ready : ba.cmd_ready;
  endfunction

  function automatic logic dn(input int s);
    return s != 0 ? bb.cmd_done : ba.cmd_done;
  endfunction

  task automatic drive(input int s, input logic [1:0] op, input int ch, input logic [23:0] f,
                       input logic [11:0] ph, input logic [1:0] wv);
    if (s != 0) begin
      bb.cmd_op = op; bb.cmd_ch = 2'(ch); bb.cmd_freq = f; bb.cmd_phase = ph; bb.cmd_wave = wv;
      bb.cmd_valid = 1'b1;
    end else begin
      ba.cmd_op = op; ba.cmd_ch = 1'(ch); ba.cmd_freq = f; ba.cmd_phase = ph; ba.cmd_wave = wv;
      ba.cmd_valid = 1'b1;
    end
  endtask

  task automatic unvalid(input int s);
    if (s != 0) bb.cmd_valid = 1'b0;
    else ba.cmd_valid = 1'b0;
  endtask

  task automatic xact(input string tag, input int s, input logic [1:0] op, input int ch,
                      input logic [23:0] f, input logic [11:0] ph, input logic [1:0] wv,
                      input int nw, input logic [15:0] w0, input logic [15:0] w1,
                      input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] ew [4];
    int base, n, per, lowt;
    ew   = '{w0, w1, w2, w3};
    per  = s != 0 ? 34 : 69;
    lowt = s != 0 ? 32 : 64;
    @(negedge clk);
    base = m_n[s];
    drive(s, op, ch, f, ph, wv);
    n = 0;
    while (!rdy(s) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 32'(rdy(s)), 32'd1);
    @(posedge clk);
    #1;
    unvalid(s);
    chk({tag, " busy"}, 32'(rdy(s)), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dn(s) && n < 2000);
    chk({tag, " latency"}, 32'(n), 32'(1 + nw * per));
    chk({tag, " ready@done"}, 32'(rdy(s)), 32'd1);
    chk({tag, " nwords"}, 32'(m_n[s] - base), 32'(nw));
    for (int k = 0; k < nw && k < 4; k++) begin
      chk($sformatf("%s word%0d", tag, k), 32'(m_word[s][base + k]), 32'(ew[k]));
      chk($sformatf("%s ch%0d", tag, k), 32'(m_ch[s][base + k]), 32'(ch));
      chk($sformatf("%s low%0d", tag, k), 32'(m_low[s][base + k]), 32'(lowt));
      chk($sformatf("%s bits%0d", tag, k), 32'(m_bits[s][base + k]), 32'd16);
    end
  endtask

  initial begin
    int n, base;
    rst_a = 1'b0;
    rst_b = 1'b0;
    ba.cmd_valid = 1'b0; ba.cmd_op = 2'd0; ba.cmd_ch = '0; ba.cmd_freq = '0; ba.cmd_phase = '0; ba.cmd_wave = '0;
    bb.cmd_valid = 1'b0; bb.cmd_op = 2'd0; bb.cmd_ch = '0; bb.cmd_freq = '0; bb.cmd_phase = '0; bb.cmd_wave = '0;
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(ba.cmd_ready), 32'd0);
    chk("rst done", 32'(ba.cmd_done), 32'd0);
    chk("rst err", 32'(ba.cmd_err), 32'd0);
    chk("rst sclk", 32'(sclk_a), 32'd1);
    chk("rst sdata", 32'(sdata_a), 32'd0);
    chk("rst fsync", 32'(fs_a), 32'h3);
    chk("rst state", 32'(st_a), 32'd0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    chk("ready before edge", 32'(ba.cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("ready after edge", 32'(ba.cmd_ready), 32'd1);

    xact("init0", 0, 2'd0, 0, 24'd0, 12'h0, 2'd0, 1, 16'h2100, 16'h0, 16'h0, 16'h0);
    xact("setf1", 0, 2'd1, 1, 24'd1000, 12'h0, 2'd0, 4, 16'h2100, 16'h69F1, 16'h4000, 16'hC000);
    xact("setf1tri", 0, 2'd1, 1, 24'd1000, 12'hABC, 2'd1, 4, 16'h2102, 16'h69F1, 16'h4000, 16'hCABC);
    xact("en1tri", 0, 2'd2, 1, 24'd0, 12'h0, 2'd0, 1, 16'h2002, 16'h0, 16'h0, 16'h0);
    xact("init1", 0, 2'd0, 1, 24'd0, 12'h0, 2'd0, 1, 16'h2100, 16'h0, 16'h0, 16'h0);
    xact("en1clr", 0, 2'd2, 1, 24'd0, 12'h0, 2'd0, 1, 16'h2000, 16'h0, 16'h0, 16'h0);
    xact("setfmax", 0, 2'd1, 0, 24'hFFFFFF, 12'h0, 2'd2, 4, 16'h2128, 16'h46F5, 16'h6AF3, 16'hC000);
    xact("en0", 0, 2'd2, 0, 24'd0, 12'h0, 2'd0, 1, 16'h2028, 16'h0, 16'h0, 16'h0);
    xact("dis0", 0, 2'd3, 0, 24'd0, 12'h0, 2'd0, 1, 16'h2128, 16'h0, 16'h0, 16'h0);

    // reset in the middle of a SET_FREQ word
    @(negedge clk);
    drive(0, 2'd1, 0, 24'd1000, 12'h0, 2'd0);
    @(posedge clk);
    #1;
    unvalid(0);
    n = 0;
    while (cur_bits[0] != 7 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid 7th fall", 32'(cur_bits[0]), 32'd7);
    chk("mid fsync low", 32'(fs_a), 32'h2);
    rst_a = 1'b0;
    #1;
    chk("abort fsync", 32'(fs_a), 32'h3);
    chk("abort sclk", 32'(sclk_a), 32'd1);
    chk("abort sdata", 32'(sdata_a), 32'd0);
    chk("abort ready", 32'(ba.cmd_ready), 32'd0);
    chk("abort state", 32'(st_a), 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst ready", 32'(ba.cmd_ready), 32'd1);
    xact("en0 post rst", 0, 2'd2, 0, 24'd0, 12'h0, 2'd0, 1, 16'h2000, 16'h0, 16'h0, 16'h0);

    // bad channel on the 3-channel instance
    @(negedge clk);
    base = m_n[1];
    drive(1, 2'd2, 3, 24'd0, 12'h0, 2'd0);
    chk("bad ready", 32'(bb.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    unvalid(1);
    @(negedge clk);
    chk("bad err", 32'(bb.cmd_err), 32'd1);
    chk("bad ready after", 32'(bb.cmd_ready), 32'd1);
    chk("bad state", 32'(st_b), 32'd0);
    @(negedge clk);
    chk("bad err pulse", 32'(bb.cmd_err), 32'd0);
    repeat (40) @(negedge clk);
    chk("bad no frame", 32'(m_n[1] - base), 32'd0);

    // back-to-back commands with valid held high
    @(negedge clk);
    base = m_n[1];
    drive(1, 2'd2, 2, 24'd0, 12'h0, 2'd0);
    @(posedge clk);
    #1;
    drive(1, 2'd3, 1, 24'd0, 12'h0, 2'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bb.cmd_done && n < 200);
    chk("b2b lat1", 32'(n), 32'd35);
    chk("b2b ready@done", 32'(bb.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    unvalid(1);
    chk("b2b accepted", 32'(bb.cmd_ready), 32'd0);
    chk("b2b load", 32'(st_b), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bb.cmd_done && n < 200);
    chk("b2b lat2", 32'(n), 32'd35);
    chk("b2b nwords", 32'(m_n[1] - base), 32'd2);
    chk("b2b word0", 32'(m_word[1][base]), 32'h2000);
    chk("b2b ch0", 32'(m_ch[1][base]), 32'd2);
    chk("b2b low0", 32'(m_low[1][base]), 32'd32);
    chk("b2b word1", 32'(m_word[1][base + 1]), 32'h2100);
    chk("b2b ch1", 32'(m_ch[1][base + 1]), 32'd1);
    chk("b2b low1", 32'(m_low[1][base + 1]), 32'd32);
    chk("one fsync low", 32'(n_multi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
